uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Boot sequencer between the UART byte receiver and the core's instruction memory. Parses a framed program image from the serial byte stream (length header, payload words, checksum) and writes each assembled 32-bit word into instruction memory. Holds the CPU in reset until the image is loaded and the checksum passes. Sits at top level between the UART receive path, the imem write port and the CPU reset input.

Parameters:
ADDR_W, 10, imem word-address width.
MAX_WORDS, 1024, largest accepted word count; must be <= 2**ADDR_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
rx_data  input  8  received byte; valid only while rx_valid=1.
rx_valid  input  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
imem_addr  output  ADDR_W  word address for the write.
imem_wdata  output  32  word to write.
cpu_rst  output  1  CPU reset; 1 until a good image is loaded.
boot_done  output  1  image loaded and checksum matched; sticky.
boot_err  output  1  length or checksum failure; sticky.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-image): state=HDR; byte, word and sum counters cleared; imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, boot_done=0, boot_err=0. rx_valid is ignored in the rst cycle.
- The block acts only on cycles with rx_valid=1. All outputs are registered.
- Frame format: 4-byte word count N, little-endian; then N words of 4 bytes each, little-endian (first byte goes to wdata[7:0]); then 1 checksum byte.
- Checksum: running 8-bit sum (mod 256) of every header and payload byte. The frame passes when running sum + checksum byte == 8'h00.
- HDR state: collects 4 bytes.
  - On the 4th byte, the complete N is evaluated combinationally from the byte just received, with no gap cycle.
  - N==0 -> SUM.
  - N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA state: a 2-bit byte index assembles each word.
  - On the 4th byte of a word: next cycle imem_we=1, imem_wdata=assembled word, imem_addr=word index (0, 1, 2, ...).
  - The word index increments after each write.
  - After word N-1 is written -> SUM.
  - imem_we is low on every other cycle.
  - Back-to-back rx_valid must not lose bytes: the next word's first byte may arrive in the same cycle imem_we is high.
- SUM state: the next byte is the checksum.
  - Pass: -> DONE. Next cycle cpu_rst=0, boot_done=1.
  - Fail: -> ERR. Next cycle boot_err=1, cpu_rst stays 1.
- DONE and ERR are terminal until rst. Further rx_valid bytes are ignored, with no imem writes and no output change.
- ERR entered on length: boot_err=1 the cycle after the 4th header byte. No imem writes occur.
- The word-index counter is ADDR_W+1 bits wide so that N==MAX_WORDS==2**ADDR_W terminates correctly. imem_addr takes its low ADDR_W bits.
- boot_done and boot_err are never both 1.

Test Plan:
- Good 1-word image: bytes 01 00 00 00 01 02 03 04 F5 -> one imem_we pulse, addr=0, wdata=32'h04030201, the cycle after byte 04; boot_done=1 and cpu_rst=0 the cycle after F5; boot_err=0.
- Bad checksum: same stream ending F4 -> the same single write occurs, then boot_err=1, cpu_rst=1, boot_done=0.
- Zero length: 00 00 00 00 00 -> no imem_we; boot_done=1. Length overflow with MAX_WORDS=1024: 01 04 00 00 (N=1025) -> boot_err=1 the next cycle; later bytes cause no writes.
- Back-to-back: N=3 with rx_valid high on 17 consecutive cycles, words 11111111/22222222/33333333, correct checksum -> writes at addr 0, 1, 2 exactly 4 cycles apart with correct data; boot_done=1.
- Reset mid-image: rst asserted after the 2nd payload byte -> all outputs return to reset values. A following full good 1-word frame loads correctly at addr 0 with no stale partial-word bytes.
- Post-terminal bytes: after boot_done, send 10 arbitrary bytes -> no imem_we, cpu_rst stays 0, flags unchanged.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Boot sequencer: parses a length/payload/checksum frame from the UART byte
// stream, writes 32-bit words into instruction memory, then releases the CPU.
module uart_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [2:0] {HDR, DATA, SUM, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [23:0]       buf_q, buf_d;
    logic              we_d, cpu_rst_d, done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    // Header and data words share one shift buffer; the 4th byte completes it.
    logic [7:0]      sum_nx;
    logic [31:0]     word_nx;
    logic [ADDR_W:0] word_inc;
    assign sum_nx   = sum_q + rx_data;
    assign word_nx  = {rx_data, buf_q};
    assign word_inc = word_idx_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            word_cnt_q <= '0;
            sum_q      <= '0;
            buf_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_cnt_q <= word_cnt_d;
            sum_q      <= sum_d;
            buf_q      <= buf_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            cpu_rst    <= cpu_rst_d;
            boot_done  <= done_d;
            boot_err   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_cnt_d = word_cnt_q;
        sum_d      = sum_q;
        buf_d      = buf_q;
        we_d       = 1'b0;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        cpu_rst_d  = cpu_rst;
        done_d     = boot_done;
        err_d      = boot_err;
        if (rx_valid) begin
            case (state_q)
                HDR, DATA: begin
                    sum_d      = sum_nx;
                    buf_d      = word_nx[31:8];
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (state_q == HDR) begin
                            if (word_nx == 32'd0) begin
                                state_d = SUM;
                            end else if (word_nx > 32'(MAX_WORDS)) begin
                                state_d = ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d    = DATA;
                                word_cnt_d = word_nx[ADDR_W:0];
                            end
                        end else begin
                            we_d       = 1'b1;
                            wdata_d    = word_nx;
                            addr_d     = word_idx_q[ADDR_W-1:0];
                            word_idx_d = word_inc;
                            if (word_inc == word_cnt_q)
                                state_d = SUM;
                        end
                    end
                end
                SUM: begin
                    if (sum_nx == 8'h00) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: vector table plus back-to-back and
// maximum-length sequences.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        boot_done;
    logic        boot_err;

    int checks = 0;
    int errors = 0;

    uart_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        cr;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic we, input logic [9:0] addr, input logic [31:0] wd,
                       input logic cr, input logic dn, input logic er);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.we = we; t.addr = addr; t.wd = wd;
        t.cr = cr; t.dn = dn; t.er = er;
        vecs.push_back(t);
    endtask

    task automatic rst_row();
        add(1'b1, 1'b1, 8'h5A, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic bt(input logic [7:0] d, input logic cr, input logic dn, input logic er);
        add(1'b0, 1'b1, d, 1'b0, 10'd0, 32'd0, cr, dn, er);
    endtask

    task automatic idle(input logic [7:0] d, input logic cr, input logic dn, input logic er);
        add(1'b0, 1'b0, d, 1'b0, 10'd0, 32'd0, cr, dn, er);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst = r; rx_valid = v; rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic cr, input logic dn, input logic er);
        chk({tag, " cpu_rst"}, 32'(cpu_rst), 32'(cr));
        chk({tag, " boot_done"}, 32'(boot_done), 32'(dn));
        chk({tag, " boot_err"}, 32'(boot_err), 32'(er));
    endtask

    initial begin
        logic [7:0]  bb [17];
        logic [7:0]  sum;
        logic [31:0] w;
        int          nwr;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

        // good 1-word image, idle gap, then ten ignored post-terminal bytes
        rst_row();
        bt(8'h01, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0);
        bt(8'h01, 1, 0, 0); bt(8'h02, 1, 0, 0); bt(8'h03, 1, 0, 0);
        add(0, 1, 8'h04, 1, 10'd0, 32'h04030201, 1, 0, 0);
        idle(8'hAA, 1, 0, 0);
        bt(8'hF5, 0, 1, 0);
        for (int i = 0; i < 10; i++) bt(8'(8'h30 + i * 7), 0, 1, 0);

        // bad checksum: the write still occurs, then error
        rst_row();
        bt(8'h01, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0);
        bt(8'h01, 1, 0, 0); bt(8'h02, 1, 0, 0); bt(8'h03, 1, 0, 0);
        add(0, 1, 8'h04, 1, 10'd0, 32'h04030201, 1, 0, 0);
        bt(8'hF4, 1, 0, 1);
        bt(8'h0C, 1, 0, 1);

        // zero length
        rst_row();
        bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0);
        bt(8'h00, 0, 1, 0);

        // length 1025 exceeds MAX_WORDS: error right after the 4th header byte
        rst_row();
        bt(8'h01, 1, 0, 0); bt(8'h04, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 1'b0, 1'b1 & 1'b0);
        vecs[vecs.size()-1].er = 1'b1;
        for (int i = 0; i < 6; i++) bt(8'(8'h05 + i), 1, 0, 1);

        // reset mid-image, then a fresh frame must land at addr 0 unpolluted
        rst_row();
        bt(8'h01, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0);
        bt(8'hEE, 1, 0, 0); bt(8'hDD, 1, 0, 0);
        rst_row();
        bt(8'h01, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0); bt(8'h00, 1, 0, 0);
        bt(8'hA1, 1, 0, 0); bt(8'hB2, 1, 0, 0); bt(8'hC3, 1, 0, 0);
        add(0, 1, 8'hD4, 1, 10'd0, 32'hD4C3B2A1, 1, 0, 0);
        bt(8'h15, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            chk({tag, " imem_we"}, 32'(imem_we), 32'(vecs[i].we));
            if (vecs[i].we || vecs[i].r) begin
                chk({tag, " imem_addr"}, 32'(imem_addr), 32'(vecs[i].addr));
                chk({tag, " imem_wdata"}, imem_wdata, vecs[i].wd);
            end
            chk_flags(tag, vecs[i].cr, vecs[i].dn, vecs[i].er);
            chk({tag, " done_err_excl"}, 32'(boot_done & boot_err), 32'd0);
        end

        // back-to-back N=3, 17 consecutive valid bytes; writes every 4 cycles
        bb = '{8'h03, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h33, 8'h33, 8'h65};
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) begin
            logic exp_we;
            step(1'b0, 1'b1, bb[k]);
            exp_we = (k == 7 || k == 11 || k == 15);
            chk($sformatf("b2b%0d imem_we", k), 32'(imem_we), 32'(exp_we));
            if (exp_we) begin
                chk($sformatf("b2b%0d imem_addr", k), 32'(imem_addr), 32'((k - 7) / 4));
                chk($sformatf("b2b%0d imem_wdata", k), imem_wdata, 32'h11111111 * 32'((k - 3) / 4));
            end
        end
        chk_flags("b2b end", 1'b0, 1'b1, 1'b0);

        // N == MAX_WORDS == 2**ADDR_W: word counter needs its extra bit
        step(1'b1, 1'b0, 8'h00);
        sum = 8'h00;
        nwr = 0;
        bb[0] = 8'h00; bb[1] = 8'h04; bb[2] = 8'h00; bb[3] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, bb[k]);
            sum = sum + bb[k];
        end
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) * 32'h00010003 + 32'h5A000000;
            for (int k = 0; k < 4; k++) begin
                logic [7:0] by;
                by = w[8*k +: 8];
                step(1'b0, 1'b1, by);
                sum = sum + by;
                if (imem_we) nwr++;
                if (k == 3) begin
                    if (!imem_we || imem_addr != 10'(i) || imem_wdata != w)
                        chk($sformatf("max word%0d addr/data", i),
                            {imem_we, 11'(imem_addr), imem_wdata[19:0]},
                            {1'b1, 11'(i), w[19:0]});
                end
            end
        end
        chk("max write count", 32'(nwr), 32'd1024);
        chk_flags("max before sum", 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'(-sum));
        chk("max sum imem_we", 32'(imem_we), 32'd0);
        chk_flags("max end", 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
